// File: rtl/seg7_scan_decoder.sv
// Samples a scanned 4-digit 7-segment display and rebuilds the shown digits as BCD nibbles.
// Optional macro DECODE_HEX_EN adds A..F glyph decoding.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  digits,
    input  logic [7:0]  segments,
    output logic [15:0] value,
    output logic [3:0]  digit_ok,
    output logic        frame_valid,
    output logic        frame_pulse,
    output logic        sel_err
);
    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t         state_reg, state_next;
    logic [3:0]     dig_meta_reg, dig_sync_reg, sel_last_reg;
    logic [6:0]     seg_meta_reg, seg_sync_reg, seg_last_reg;
    logic [1:0]     idx_reg, idx_next;
    logic [SCW-1:0] cnt_reg, cnt_next;
    logic [TOW-1:0] tcnt_reg;
    logic [3:0]     mask_reg;
    logic [3:0]     shadow_reg [4];
    logic [3:0]     shadow_ok_reg;
    logic           publish_reg;
    logic [15:0]    value_reg;
    logic [3:0]     digit_ok_reg;
    logic           frame_valid_reg, frame_pulse_reg, sel_err_reg;

    logic           sel_legal, sel_blank, sel_illegal, sel_changed, seg_changed;
    logic [1:0]     sel_idx;
    logic [3:0]     glyph_nib;
    logic           glyph_ok;
    logic           capture;
    logic           unused_dp;

    assign unused_dp = segments[7];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig_meta_reg <= 4'hF;
            dig_sync_reg <= 4'hF;
            sel_last_reg <= 4'hF;
            seg_meta_reg <= '0;
            seg_sync_reg <= '0;
            seg_last_reg <= '0;
        end else begin
            dig_meta_reg <= digits;
            dig_sync_reg <= dig_meta_reg;
            sel_last_reg <= dig_sync_reg;
            seg_meta_reg <= segments[6:0];
            seg_sync_reg <= seg_meta_reg;
            seg_last_reg <= seg_sync_reg;
        end
    end

    always_comb begin
        sel_legal = 1'b0;
        sel_blank = 1'b0;
        sel_idx   = 2'd0;
        case (dig_sync_reg)
            4'b1110: begin sel_legal = 1'b1; sel_idx = 2'd0; end
            4'b1101: begin sel_legal = 1'b1; sel_idx = 2'd1; end
            4'b1011: begin sel_legal = 1'b1; sel_idx = 2'd2; end
            4'b0111: begin sel_legal = 1'b1; sel_idx = 2'd3; end
            4'b1111: sel_blank = 1'b1;
            default: ;
        endcase
    end

    assign sel_illegal = !sel_legal && !sel_blank;
    assign sel_changed = (dig_sync_reg != sel_last_reg);
    assign seg_changed = (seg_sync_reg != seg_last_reg);

    always_comb begin
        glyph_nib = 4'hF;
        glyph_ok  = 1'b1;
        case (seg_sync_reg)
            7'h3F: glyph_nib = 4'h0;
            7'h06: glyph_nib = 4'h1;
            7'h5B: glyph_nib = 4'h2;
            7'h4F: glyph_nib = 4'h3;
            7'h66: glyph_nib = 4'h4;
            7'h6D: glyph_nib = 4'h5;
            7'h7D: glyph_nib = 4'h6;
            7'h07: glyph_nib = 4'h7;
            7'h7F: glyph_nib = 4'h8;
            7'h6F: glyph_nib = 4'h9;
`ifdef DECODE_HEX_EN
            7'h77: glyph_nib = 4'hA;
            7'h7C: glyph_nib = 4'hB;
            7'h39: glyph_nib = 4'hC;
            7'h5E: glyph_nib = 4'hD;
            7'h79: glyph_nib = 4'hE;
            7'h71: glyph_nib = 4'hF;
`endif
            default: begin
                glyph_nib = 4'hF;
                glyph_ok  = 1'b0;
            end
        endcase
    end

    // Any select change leaves the current digit: re-arm on a new legal index, otherwise idle.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel_legal) begin
                    state_next = SETTLE;
                    idx_next   = sel_idx;
                    cnt_next   = '0;
                end
            end
            SETTLE: begin
                if (sel_changed) begin
                    cnt_next = '0;
                    if (sel_legal) begin
                        idx_next = sel_idx;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (seg_changed) begin
                    cnt_next = '0;
                end else if (cnt_reg == SCW'(STABLE_CYCLES - 1)) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                if (sel_changed) begin
                    cnt_next = '0;
                    if (sel_legal) begin
                        state_next = SETTLE;
                        idx_next   = sel_idx;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_shadow
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    shadow_reg[gi]    <= '0;
                    shadow_ok_reg[gi] <= 1'b0;
                end else if (capture && idx_reg == 2'(gi)) begin
                    shadow_reg[gi]    <= glyph_nib;
                    shadow_ok_reg[gi] <= glyph_ok;
                end
            end
        end
    endgenerate

    // Digit 3 closes a frame; it is published only if digits 0..2 were all captured since the last close.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_reg        <= '0;
            publish_reg     <= 1'b0;
            tcnt_reg        <= '0;
            value_reg       <= '0;
            digit_ok_reg    <= '0;
            frame_valid_reg <= 1'b0;
            frame_pulse_reg <= 1'b0;
            sel_err_reg     <= 1'b0;
        end else begin
            publish_reg     <= 1'b0;
            frame_pulse_reg <= publish_reg;
            sel_err_reg     <= sel_illegal && sel_changed;
            if (capture) begin
                if (idx_reg == 2'd3) begin
                    mask_reg    <= '0;
                    publish_reg <= &mask_reg[2:0];
                end else begin
                    mask_reg[idx_reg] <= 1'b1;
                end
            end
            if (capture) begin
                tcnt_reg <= '0;
            end else if (tcnt_reg != TOW'(TIMEOUT_CYCLES - 1)) begin
                tcnt_reg <= tcnt_reg + 1'b1;
            end
            if (publish_reg) begin
                value_reg       <= {shadow_reg[3], shadow_reg[2], shadow_reg[1], shadow_reg[0]};
                digit_ok_reg    <= shadow_ok_reg;
                frame_valid_reg <= 1'b1;
            end else if (!capture && tcnt_reg == TOW'(TIMEOUT_CYCLES - 1)) begin
                frame_valid_reg <= 1'b0;
            end
        end
    end

    assign value       = value_reg;
    assign digit_ok    = digit_ok_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_pulse = frame_pulse_reg;
    assign sel_err     = sel_err_reg;
endmodule
